// File: rtl/if_stage.sv
// if_stage -- instruction fetch stage with IF/ID pipeline register.
//
// Holds the PC and drives it straight to instruction memory. The IF/ID
// register captures the fetched word one cycle later. A redirect (PCSrc)
// overrides any stall on both registers and turns IF/ID into a NOP bubble.
// Two saturating counters record how many edges were stall cycles and how
// many were redirect cycles.
//
// Ports:
//   clk            in   clock, rising edge
//   reset          in   synchronous active-high reset
//   PCwrite        in   1 = PC advances by 4, 0 = PC holds
//   IF_IDwrite     in   1 = IF/ID loads, 0 = IF/ID holds
//   PCSrc          in   1 = redirect to branch_target and flush IF/ID
//   branch_target  in   redirect address (low two bits are ignored)
//   inst_addr      out  current PC
//   inst_data      in   instruction word for inst_addr, same cycle
//   IF_ID_pc       out  PC of the instruction in IF/ID
//   IF_ID_pc4      out  IF_ID_pc + 4
//   IF_ID_inst     out  instruction in IF/ID
//   IF_ID_valid    out  1 = real instruction, 0 = bubble
//   stall_count    out  saturating count of stall edges
//   flush_count    out  saturating count of redirect edges
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP      = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        PCwrite,
   input  logic        IF_IDwrite,
   input  logic        PCSrc,
   input  logic [31:0] branch_target,
   output logic [31:0] inst_addr,
   input  logic [31:0] inst_data,
   output logic [31:0] IF_ID_pc,
   output logic [31:0] IF_ID_pc4,
   output logic [31:0] IF_ID_inst,
   output logic        IF_ID_valid,
   output logic [31:0] stall_count,
   output logic [31:0] flush_count
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] pc_plus4;
   logic [31:0] ifid_pc_q, ifid_pc_d;
   logic [31:0] ifid_pc4_q, ifid_pc4_d;
   logic [31:0] ifid_inst_q, ifid_inst_d;
   logic        ifid_valid_q, ifid_valid_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   // 32-bit add wraps naturally at the top of the address space
   assign pc_plus4 = pc_q + 32'd4;

   // PC next state: redirect beats stall
   always_comb begin
      pc_d = pc_q;
      if (PCSrc)
         pc_d = {branch_target[31:2], 2'b00};
      else if (PCwrite)
         pc_d = pc_plus4;
   end

   // IF/ID next state: redirect flushes even when IF/ID is held
   always_comb begin
      ifid_pc_d    = ifid_pc_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_inst_d  = ifid_inst_q;
      ifid_valid_d = ifid_valid_q;
      if (PCSrc) begin
         ifid_pc_d    = 32'd0;
         ifid_pc4_d   = 32'd4;
         ifid_inst_d  = NOP;
         ifid_valid_d = 1'b0;
      end else if (IF_IDwrite) begin
         ifid_pc_d    = pc_q;
         ifid_pc4_d   = pc_plus4;
         ifid_inst_d  = inst_data;
         ifid_valid_d = 1'b1;
      end
   end

   // Counters: a redirect edge is never also counted as a stall edge
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (PCSrc) begin
         if (flush_cnt_q != 32'hFFFF_FFFF)
            flush_cnt_d = flush_cnt_q + 32'd1;
      end else if (!PCwrite) begin
         if (stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q         <= RESET_PC;
         ifid_pc_q    <= 32'd0;
         ifid_pc4_q   <= 32'd4;
         ifid_inst_q  <= NOP;
         ifid_valid_q <= 1'b0;
         stall_cnt_q  <= 32'd0;
         flush_cnt_q  <= 32'd0;
      end else begin
         pc_q         <= pc_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_pc4_q   <= ifid_pc4_d;
         ifid_inst_q  <= ifid_inst_d;
         ifid_valid_q <= ifid_valid_d;
         stall_cnt_q  <= stall_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
      end
   end

   assign inst_addr   = pc_q;
   assign IF_ID_pc    = ifid_pc_q;
   assign IF_ID_pc4   = ifid_pc4_q;
   assign IF_ID_inst  = ifid_inst_q;
   assign IF_ID_valid = ifid_valid_q;
   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage. Instruction memory is modelled as
// inst_data = inst_addr ^ KEY so each fetched word identifies its address.
module tb_if_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] KEY = 32'hDEAD_0000;

   logic        clk = 1'b0;
   logic        reset, PCwrite, IF_IDwrite, PCSrc;
   logic [31:0] branch_target, inst_addr, inst_data;
   logic [31:0] IF_ID_pc, IF_ID_pc4, IF_ID_inst, stall_count, flush_count;
   logic        IF_ID_valid;

   int passed = 0;
   int total  = 0;
   int fails  = 0;

   if_stage dut (
      .clk(clk), .reset(reset), .PCwrite(PCwrite), .IF_IDwrite(IF_IDwrite),
      .PCSrc(PCSrc), .branch_target(branch_target), .inst_addr(inst_addr),
      .inst_data(inst_data), .IF_ID_pc(IF_ID_pc), .IF_ID_pc4(IF_ID_pc4),
      .IF_ID_inst(IF_ID_inst), .IF_ID_valid(IF_ID_valid),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   always #5 clk = ~clk;
   assign inst_data = inst_addr ^ KEY;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic pw, input logic iw,
                        input logic ps, input logic [31:0] bt);
      reset = r; PCwrite = pw; IF_IDwrite = iw; PCSrc = ps; branch_target = bt;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      drive(1, 1, 1, 1, 32'h0000_0ABC);
      step();
      step();
      chk("rst_addr",  inst_addr,   32'h0);
      chk("rst_valid", {31'd0, IF_ID_valid}, 32'd0);
      chk("rst_pc",    IF_ID_pc,    32'h0);
      chk("rst_pc4",   IF_ID_pc4,   32'h4);
      chk("rst_inst",  IF_ID_inst,  NOP);
      chk("rst_stall", stall_count, 32'd0);
      chk("rst_flush", flush_count, 32'd0);

      // sequential fetch
      drive(0, 1, 1, 0, 32'h0);
      chk("seq0_addr",  inst_addr, 32'h0);
      chk("seq0_valid", {31'd0, IF_ID_valid}, 32'd0);
      step();
      chk("seq1_addr",  inst_addr,  32'h4);
      chk("seq1_pc",    IF_ID_pc,   32'h0);
      chk("seq1_inst",  IF_ID_inst, 32'hDEAD_0000);
      chk("seq1_valid", {31'd0, IF_ID_valid}, 32'd1);
      step();
      chk("seq2_addr",  inst_addr,  32'h8);
      chk("seq2_pc",    IF_ID_pc,   32'h4);
      chk("seq2_pc4",   IF_ID_pc4,  32'h8);

      // load-use stall at PC=8
      drive(0, 0, 0, 0, 32'h0);
      step();
      chk("stall_addr",  inst_addr,   32'h8);
      chk("stall_pc",    IF_ID_pc,    32'h4);
      chk("stall_inst",  IF_ID_inst,  32'hDEAD_0004);
      chk("stall_cnt",   stall_count, 32'd1);
      chk("stall_flush", flush_count, 32'd0);
      drive(0, 1, 1, 0, 32'h0);
      step();
      chk("resume_addr", inst_addr,  32'hC);
      chk("resume_pc",   IF_ID_pc,   32'h8);
      chk("resume_inst", IF_ID_inst, 32'hDEAD_0008);

      // split enables: PC moves, IF/ID holds
      drive(0, 1, 0, 0, 32'h0);
      step();
      chk("splitA_addr",  inst_addr,   32'h10);
      chk("splitA_pc",    IF_ID_pc,    32'h8);
      chk("splitA_stall", stall_count, 32'd1);
      // split enables: PC holds, IF/ID loads
      drive(0, 0, 1, 0, 32'h0);
      step();
      chk("splitB_addr",  inst_addr,   32'h10);
      chk("splitB_pc",    IF_ID_pc,    32'h10);
      chk("splitB_inst",  IF_ID_inst,  32'hDEAD_0010);
      chk("splitB_stall", stall_count, 32'd2);

      // redirect while a stall is requested
      drive(0, 0, 0, 1, 32'h0000_0103);
      step();
      chk("redir_addr",  inst_addr,   32'h100);
      chk("redir_inst",  IF_ID_inst,  NOP);
      chk("redir_valid", {31'd0, IF_ID_valid}, 32'd0);
      chk("redir_pc",    IF_ID_pc,    32'h0);
      chk("redir_pc4",   IF_ID_pc4,   32'h4);
      chk("redir_flush", flush_count, 32'd1);
      chk("redir_stall", stall_count, 32'd2);
      drive(0, 1, 1, 0, 32'h0);
      step();
      chk("post_addr", inst_addr,  32'h104);
      chk("post_pc",   IF_ID_pc,   32'h100);
      chk("post_pc4",  IF_ID_pc4,  32'h104);
      chk("post_inst", IF_ID_inst, 32'hDEAD_0100);

      // wrap at top of address space
      drive(0, 1, 1, 1, 32'hFFFF_FFFE);
      step();
      chk("wrapA_addr",  inst_addr,   32'hFFFF_FFFC);
      chk("wrapA_flush", flush_count, 32'd2);
      drive(0, 1, 1, 0, 32'h0);
      step();
      chk("wrapB_addr",  inst_addr,  32'h0);
      chk("wrapB_pc",    IF_ID_pc,   32'hFFFF_FFFC);
      chk("wrapB_pc4",   IF_ID_pc4,  32'h0);
      chk("wrapB_inst",  IF_ID_inst, 32'h2152_FFFC);
      chk("wrapB_valid", {31'd0, IF_ID_valid}, 32'd1);

      // reset during redirect with nonzero counters
      drive(1, 0, 1, 1, 32'h0000_0200);
      step();
      chk("mrst_addr",  inst_addr,   32'h0);
      chk("mrst_valid", {31'd0, IF_ID_valid}, 32'd0);
      chk("mrst_inst",  IF_ID_inst,  NOP);
      chk("mrst_stall", stall_count, 32'd0);
      chk("mrst_flush", flush_count, 32'd0);
      drive(0, 1, 1, 0, 32'h0);
      chk("rel0_addr",  inst_addr, 32'h0);
      step();
      chk("rel1_addr",  inst_addr, 32'h4);
      chk("rel1_pc",    IF_ID_pc,  32'h0);
      chk("rel1_valid", {31'd0, IF_ID_valid}, 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
